// File: rtl/rv32i_core.sv
// Single-issue RV32I core: registered fetch PC, combinational decode/execute, one regfile write per edge.
// Loads and stores take the shared memory port for one cycle by stalling fetch.
module rv32i_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] pc,
  input  logic [31:0] instruction_code,
  output logic        stall_pc,
  output logic [31:0] mem_addr,
  output logic        mem_rw_mode,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_read_data,
  output logic        ignore_curr_inst
);

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] lane;
  } ld_req_t;

  logic [31:0] r_pc, r_exec_pc;
  logic        r_ignore;
  logic        r_ld_pend;
  ld_req_t     r_ld;
  logic [31:0] r_rf [32];

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_alt;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1v, w_rs2v, w_alu_b, w_alu, w_addr;
  logic        w_br_take;
  logic        w_redirect, w_load, w_store;
  logic [31:0] w_target;
  logic        w_rf_we;
  logic [4:0]  w_rf_wa;
  logic [31:0] w_rf_wd;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_b;
  logic [15:0] w_ld_h;
  logic [31:0] w_ld_val;

  assign w_opcode = instruction_code[6:0];
  assign w_rd     = instruction_code[11:7];
  assign w_f3     = instruction_code[14:12];
  assign w_rs1    = instruction_code[19:15];
  assign w_rs2    = instruction_code[24:20];
  assign w_alt    = instruction_code[30];

  assign w_imm_i = {{20{instruction_code[31]}}, instruction_code[31:20]};
  assign w_imm_s = {{20{instruction_code[31]}}, instruction_code[31:25], instruction_code[11:7]};
  assign w_imm_b = {{19{instruction_code[31]}}, instruction_code[31], instruction_code[7],
                    instruction_code[30:25], instruction_code[11:8], 1'b0};
  assign w_imm_u = {instruction_code[31:12], 12'b0};
  assign w_imm_j = {{11{instruction_code[31]}}, instruction_code[31], instruction_code[19:12],
                    instruction_code[20], instruction_code[30:21], 1'b0};

  // x0 is never written, so it reads back as zero
  assign w_rs1v = r_rf[w_rs1];
  assign w_rs2v = r_rf[w_rs2];

  assign w_alu_b = (w_opcode == OP_REG) ? w_rs2v : w_imm_i;
  assign w_addr  = w_rs1v + ((w_opcode == OP_ST) ? w_imm_s : w_imm_i);

  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'd0: w_alu = (w_opcode == OP_REG && w_alt) ? w_rs1v - w_alu_b : w_rs1v + w_alu_b;
      3'd1: w_alu = w_rs1v << w_alu_b[4:0];
      3'd2: w_alu = ($signed(w_rs1v) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
      3'd3: w_alu = (w_rs1v < w_alu_b) ? 32'd1 : 32'd0;
      3'd4: w_alu = w_rs1v ^ w_alu_b;
      3'd5: w_alu = w_alt ? 32'($signed(w_rs1v) >>> w_alu_b[4:0]) : w_rs1v >> w_alu_b[4:0];
      3'd6: w_alu = w_rs1v | w_alu_b;
      default: w_alu = w_rs1v & w_alu_b;
    endcase
  end

  always_comb begin
    w_br_take = 1'b0;
    case (w_f3)
      3'd0: w_br_take = (w_rs1v == w_rs2v);
      3'd1: w_br_take = (w_rs1v != w_rs2v);
      3'd4: w_br_take = ($signed(w_rs1v) <  $signed(w_rs2v));
      3'd5: w_br_take = ($signed(w_rs1v) >= $signed(w_rs2v));
      3'd6: w_br_take = (w_rs1v <  w_rs2v);
      3'd7: w_br_take = (w_rs1v >= w_rs2v);
      default: w_br_take = 1'b0;
    endcase
  end

  // Load response lane select, using the address bits captured at request time
  always_comb begin
    w_ld_b   = mem_read_data[{r_ld.lane, 3'b000} +: 8];
    w_ld_h   = r_ld.lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    w_ld_val = mem_read_data;
    case (r_ld.f3)
      3'd0: w_ld_val = {{24{w_ld_b[7]}}, w_ld_b};
      3'd1: w_ld_val = {{16{w_ld_h[15]}}, w_ld_h};
      3'd4: w_ld_val = {24'b0, w_ld_b};
      3'd5: w_ld_val = {16'b0, w_ld_h};
      default: w_ld_val = mem_read_data;
    endcase
  end

  // Execute; a pending load response owns the write port (that cycle is always ignored)
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wa    = w_rd;
    w_rf_wd    = '0;
    w_redirect = 1'b0;
    w_target   = '0;
    w_load     = 1'b0;
    w_store    = 1'b0;
    if (r_ld_pend) begin
      w_rf_we = 1'b1;
      w_rf_wa = r_ld.rd;
      w_rf_wd = w_ld_val;
    end else if (!r_ignore) begin
      case (w_opcode)
        OP_LUI:   begin w_rf_we = 1'b1; w_rf_wd = w_imm_u; end
        OP_AUIPC: begin w_rf_we = 1'b1; w_rf_wd = r_exec_pc + w_imm_u; end
        OP_JAL: begin
          w_rf_we    = 1'b1;
          w_rf_wd    = r_exec_pc + 32'd4;
          w_redirect = 1'b1;
          w_target   = r_exec_pc + w_imm_j;
        end
        OP_JALR: begin
          w_rf_we    = 1'b1;
          w_rf_wd    = r_exec_pc + 32'd4;
          w_redirect = 1'b1;
          w_target   = (w_rs1v + w_imm_i) & ~32'd1;
        end
        OP_BR: begin
          w_redirect = w_br_take;
          w_target   = r_exec_pc + w_imm_b;
        end
        OP_LD:           w_load  = 1'b1;
        OP_ST:           w_store = 1'b1;
        OP_IMM, OP_REG:  begin w_rf_we = 1'b1; w_rf_wd = w_alu; end
        default: ;
      endcase
    end
  end

  // Sub-word stores replicate the data across lanes; enables pick the aligned lane(s)
  always_comb begin
    w_be    = '0;
    w_wdata = w_rs2v;
    case (w_f3[1:0])
      2'd0: begin w_be = 4'b0001 << w_addr[1:0];           w_wdata = {4{w_rs2v[7:0]}};  end
      2'd1: begin w_be = w_addr[1] ? 4'b1100 : 4'b0011;    w_wdata = {2{w_rs2v[15:0]}}; end
      2'd2: begin w_be = 4'b1111;                           w_wdata = w_rs2v;            end
      default: w_be = '0;
    endcase
  end

  assign stall_pc         = w_load | w_store;
  assign mem_rw_mode      = w_store;
  assign mem_addr         = w_addr;
  assign mem_write_data   = w_wdata;
  assign mem_byte_en      = w_store ? w_be : 4'b0000;
  assign pc               = r_pc;
  assign ignore_curr_inst = r_ignore;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc      <= RESET_PC;
      r_exec_pc <= RESET_PC;
      r_ignore  <= 1'b1;
      r_ld_pend <= 1'b0;
      r_ld      <= '0;
    end else begin
      if (!stall_pc) begin
        r_exec_pc <= r_pc;
        r_pc      <= w_redirect ? w_target : r_pc + 32'd4;
      end
      r_ignore  <= w_redirect | stall_pc;
      r_ld_pend <= w_load;
      if (w_load) r_ld <= '{rd: w_rd, f3: w_f3, lane: w_addr[1:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && w_rf_wa != 5'd0) begin
      r_rf[w_rf_wa] <= w_rf_wd;
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: unified one-cycle-latency memory, directed vectors and
// random programs checked against an instruction-level reference model.
module tb_rv32i_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, instruction_code, mem_addr, mem_write_data, mem_read_data;
  logic        stall_pc, mem_rw_mode, ignore_curr_inst;
  logic [3:0]  mem_byte_en;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata = '0;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_dat = '0;
  logic [9:0]  w_idx;

  logic [31:0] rmw [0:1023];
  logic [31:0] rx  [0:31];
  int n_tests = 0, n_fail = 0;

  rv32i_core #(.RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_rst(rst_n), .pc(pc), .instruction_code(instruction_code),
    .stall_pc(stall_pc), .mem_addr(mem_addr), .mem_rw_mode(mem_rw_mode),
    .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
    .mem_read_data(mem_read_data), .ignore_curr_inst(ignore_curr_inst));

  always #5 clk = ~clk;

  // Arbiter + memory: data port wins while the core stalls fetch
  assign w_idx = stall_pc ? mem_addr[11:2] : pc[11:2];
  assign instruction_code = rdata;
  assign mem_read_data    = rdata;

  always @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_dat;
    else if (stall_pc && mem_rw_mode)
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mem[w_idx][8*b +: 8] <= mem_write_data[8*b +: 8];
    rdata <= mem[w_idx];
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ldw(input int idx, input logic [31:0] d);
    ld_we = 1'b1; ld_idx = idx[9:0]; ld_dat = d; rmw[idx] = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
  endtask

  // ---------------- reference model: one architectural instruction per step
  task automatic setx(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 0) rx[rd] = v;
  endtask

  function automatic logic [31:0] alu(int f3, logic [31:0] a, logic [31:0] b, logic alt, logic isreg);
    int sh = int'(b % 32);
    case (f3)
      0: return (isreg && alt) ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3: return (a < b) ? 1 : 0;
      4: return a ^ b;
      5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic iss_run(input logic [31:0] halt);
    logic [31:0] p, nx, ins, a, b, iI, iS, iB, iU, iJ, ad, w;
    logic [4:0] rd, s1, s2;
    int f3, steps;
    logic tk;
    for (int i = 0; i < 32; i++) rx[i] = 0;
    p = 0; steps = 0;
    while (p != halt && steps < 1000) begin
      ins = rmw[p[11:2]];
      rd = ins[11:7]; s1 = ins[19:15]; s2 = ins[24:20]; f3 = int'(ins[14:12]);
      iI = {{20{ins[31]}}, ins[31:20]};
      iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      iU = {ins[31:12], 12'b0};
      iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      a = rx[s1]; b = rx[s2]; nx = p + 4;
      case (ins[6:0])
        7'h37: setx(rd, iU);
        7'h17: setx(rd, p + iU);
        7'h6F: begin nx = p + iJ; setx(rd, p + 4); end
        7'h67: begin nx = (a + iI) & ~32'd1; setx(rd, p + 4); end
        7'h63: begin
          case (f3)
            0: tk = (a == b);
            1: tk = (a != b);
            4: tk = ($signed(a) < $signed(b));
            5: tk = ($signed(a) >= $signed(b));
            6: tk = (a < b);
            7: tk = (a >= b);
            default: tk = 1'b0;
          endcase
          if (tk) nx = p + iB;
        end
        7'h03: begin
          ad = a + iI; w = rmw[ad[11:2]];
          case (f3)
            0: setx(rd, 32'($signed(w[8*ad[1:0] +: 8])));
            1: setx(rd, 32'($signed(w[16*ad[1] +: 16])));
            4: setx(rd, {24'b0, w[8*ad[1:0] +: 8]});
            5: setx(rd, {16'b0, w[16*ad[1] +: 16]});
            default: setx(rd, w);
          endcase
        end
        7'h23: begin
          ad = a + iS;
          case (f3)
            0: rmw[ad[11:2]][8*ad[1:0] +: 8]  = b[7:0];
            1: rmw[ad[11:2]][16*ad[1] +: 16]  = b[15:0];
            default: rmw[ad[11:2]] = b;
          endcase
        end
        7'h13: setx(rd, alu(f3, a, iI, ins[30], 1'b0));
        7'h33: setx(rd, alu(f3, a, b, ins[30], 1'b1));
        default: ;
      endcase
      p = nx; steps++;
    end
  endtask

  function automatic logic [31:0] rand_inst(int pcv);
    int k, rd, s1, s2, f3, imm, t, f7;
    k = int'($urandom_range(0, 9)); rd = int'($urandom_range(1, 30));
    s1 = int'($urandom_range(0, 31)); s2 = int'($urandom_range(0, 31));
    f3 = int'($urandom_range(0, 7)); imm = int'($urandom_range(0, 4095));
    case (k)
      0: begin
        if (f3 == 1) imm = imm & 31;
        else if (f3 == 5) imm = (imm & 31) | (($urandom_range(0, 1) == 1) ? 32'h400 : 0);
        return enc_i(imm, s1, f3, rd, 7'h13);
      end
      1, 2: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32'h20 : 0;
        return enc_r(f7, s2, s1, f3, rd);
      end
      3: return enc_u(int'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      4, 5: return enc_s(int'($urandom_range(0, 255)), s2, 31, int'($urandom_range(0, 2)));
      6, 7: begin
        t = int'($urandom_range(0, 4)); f3 = (t > 2) ? t + 1 : t;
        return enc_i(int'($urandom_range(0, 255)), 31, f3, rd, 7'h03);
      end
      8: begin
        t = int'($urandom_range(0, 5)); f3 = (t < 2) ? t : t + 2;
        return enc_b(8, s2, s1, f3);
      end
      default: return ($urandom_range(0, 1) == 1) ? enc_j(8, rd) : enc_i(pcv + 8, 0, 0, rd, 7'h67);
    endcase
  endfunction

  // ---------------- directed vectors: program, register to inspect, expected value
  typedef struct packed {
    logic [3:0][31:0] p;
    logic [2:0]       np;
    logic [4:0]       rk;
    logic [31:0]      exp;
  } vec_t;
  localparam int NV = 14;
  vec_t tv [NV];

  task automatic setv(input int i, input int np, input int rk, input logic [31:0] exp,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    tv[i].p = '0;
    tv[i].p[0] = a0; tv[i].p[1] = a1; tv[i].p[2] = a2;
    tv[i].np = np[2:0]; tv[i].rk = rk[4:0]; tv[i].exp = exp;
  endtask

  logic [31:0] prog [0:127];
  logic [31:0] nop;

  initial begin
    nop = 32'h0000_0013;
    setv(0,  1, 1, 32'hFFFF_FFFF, enc_i(-1, 0, 0, 1, 7'h13), 0, 0);
    setv(1,  2, 2, 32'h0000_0001, enc_i(-1, 0, 0, 1, 7'h13), enc_r(0, 1, 0, 3, 2), 0);
    setv(2,  2, 3, 32'hFFFF_FFFF, enc_i(-1, 0, 0, 1, 7'h13), enc_i(32'h404, 1, 5, 3, 7'h13), 0);
    setv(3,  2, 4, 32'h0000_0000, enc_i(5, 0, 0, 0, 7'h13), enc_r(0, 0, 0, 0, 4), 0);
    setv(4,  2, 2, 32'hFFFF_FFFB, enc_i(5, 0, 0, 1, 7'h13), enc_r(32'h20, 1, 0, 0, 2), 0);
    setv(5,  2, 2, 32'h0000_0001, enc_u(32'h80000, 1, 7'h37), enc_i(31, 1, 5, 2, 7'h13), 0);
    setv(6,  2, 2, 32'h0000_0001, enc_i(-16, 0, 0, 1, 7'h13), enc_r(0, 0, 1, 2, 2), 0);
    setv(7,  3, 3, 32'h0000_0006, enc_i(3, 0, 0, 1, 7'h13), enc_i(33, 0, 0, 2, 7'h13), enc_r(0, 2, 1, 1, 3));
    setv(8,  2, 1, 32'h0000_0004, enc_j(8, 1), enc_i(1, 0, 0, 2, 7'h13), 0);
    setv(9,  1, 1, 32'h0000_1000, enc_u(1, 1, 7'h17), 0, 0);
    setv(10, 2, 2, 32'hFFFF_FAAA, enc_i(32'h555, 0, 0, 1, 7'h13), enc_i(-1, 1, 4, 2, 7'h13), 0);
    setv(11, 3, 3, 32'h0000_03F0, enc_i(32'h0F0, 0, 0, 1, 7'h13), enc_i(32'h300, 1, 6, 2, 7'h13), enc_i(32'h3FC, 2, 7, 3, 7'h13));
    setv(12, 2, 2, 32'h0FFF_FFFF, enc_i(-1, 0, 0, 1, 7'h13), enc_i(4, 1, 5, 2, 7'h13), 0);
    setv(13, 3, 3, 32'h0000_0000, enc_i(-1, 0, 0, 1, 7'h13), enc_i(1, 0, 0, 2, 7'h13), enc_r(0, 2, 1, 0, 3));

    for (int t = 0; t < NV; t++) begin
      do_reset();
      ldw(128, 32'hDEAD_BEEF);
      for (int k = 0; k < int'(tv[t].np); k++) ldw(k, tv[t].p[k]);
      ldw(int'(tv[t].np), enc_s(32'h200, int'(tv[t].rk), 0, 2));
      ldw(int'(tv[t].np) + 1, enc_j(0, 0));
      rst_n = 1'b1;
      tick(4 * int'(tv[t].np) + 24);
      chk($sformatf("vec%0d_x%0d", t, tv[t].rk), mem[128], tv[t].exp);
    end

    // Reset values, then a plain nop stream
    do_reset();
    for (int k = 0; k < 16; k++) ldw(k, nop);
    chk("rst_stall", {31'b0, stall_pc}, 32'd0);
    chk("rst_rw", {31'b0, mem_rw_mode}, 32'd0);
    chk("rst_be", {28'b0, mem_byte_en}, 32'd0);
    rst_n = 1'b1;
    chk("c1_pc", pc, 32'h0);
    chk("c1_ign", {31'b0, ignore_curr_inst}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("nop_pc%0d", k), pc, 32'(4 * k));
      chk($sformatf("nop_ign%0d", k), {31'b0, ignore_curr_inst}, 32'd0);
    end

    // Taken beq at 0x10 back to 0x08
    do_reset();
    for (int k = 0; k < 8; k++) ldw(k, nop);
    ldw(4, enc_b(-8, 0, 0, 0));
    rst_n = 1'b1;
    tick(6);
    chk("beq_pc", pc, 32'h08);
    chk("beq_ign", {31'b0, ignore_curr_inst}, 32'd1);
    tick();
    chk("beq_pc2", pc, 32'h0C);
    chk("beq_ign2", {31'b0, ignore_curr_inst}, 32'd0);

    // Not-taken bne keeps the sequential stream
    do_reset();
    ldw(4, enc_b(-8, 0, 0, 1));
    rst_n = 1'b1;
    tick(6);
    chk("bne_pc", pc, 32'h18);
    chk("bne_ign", {31'b0, ignore_curr_inst}, 32'd0);

    // Byte store, signed and unsigned byte loads
    do_reset();
    ldw(64, 0); ldw(128, 32'hDEAD_BEEF); ldw(129, 32'hDEAD_BEEF);
    ldw(0, enc_i(32'h100, 0, 0, 5, 7'h13));
    ldw(1, enc_u(32'h8899B, 6, 7'h37));
    ldw(2, enc_i(-1349, 6, 0, 6, 7'h13));
    ldw(3, enc_s(1, 6, 5, 0));
    ldw(4, enc_i(1, 5, 0, 7, 7'h03));
    ldw(5, enc_i(1, 5, 4, 8, 7'h03));
    ldw(6, enc_s(32'h200, 7, 0, 2));
    ldw(7, enc_s(32'h204, 8, 0, 2));
    ldw(8, enc_j(0, 0));
    rst_n = 1'b1;
    tick(4);
    chk("sb_stall", {31'b0, stall_pc}, 32'd1);
    chk("sb_rw", {31'b0, mem_rw_mode}, 32'd1);
    chk("sb_be", {28'b0, mem_byte_en}, 32'h2);
    chk("sb_data", mem_write_data, 32'hBBBB_BBBB);
    chk("sb_addr", mem_addr, 32'h101);
    chk("sb_pc", pc, 32'h10);
    tick();
    chk("sb_ign", {31'b0, ignore_curr_inst}, 32'd1);
    chk("sb_nostall", {31'b0, stall_pc}, 32'd0);
    tick();
    chk("lb_stall", {31'b0, stall_pc}, 32'd1);
    chk("lb_rw", {31'b0, mem_rw_mode}, 32'd0);
    chk("lb_be", {28'b0, mem_byte_en}, 32'd0);
    tick();
    chk("lb_ign", {31'b0, ignore_curr_inst}, 32'd1);
    chk("lb_nostall", {31'b0, stall_pc}, 32'd0);
    tick(20);
    chk("lb_val", mem[128], 32'hFFFF_FFBB);
    chk("lbu_val", mem[129], 32'h0000_00BB);
    chk("sb_mem", mem[64], 32'h0000_BB00);

    // jalr, then reset during a load response
    do_reset();
    ldw(130, 32'hDEAD_BEEF); ldw(132, 32'h1234_5678);
    ldw(0, enc_i(32'h100, 0, 0, 5, 7'h13));
    for (int k = 1; k < 8; k++) ldw(k, nop);
    ldw(8, enc_i(4, 5, 0, 1, 7'h67));
    ldw(65, enc_s(32'h208, 1, 0, 2));
    ldw(66, enc_i(32'h210, 0, 2, 10, 7'h03));
    ldw(67, enc_j(0, 0));
    rst_n = 1'b1;
    tick(10);
    chk("jalr_pc", pc, 32'h104);
    chk("jalr_ign", {31'b0, ignore_curr_inst}, 32'd1);
    tick(3);
    chk("lw_stall", {31'b0, stall_pc}, 32'd1);
    tick();
    chk("lw_resp_ign", {31'b0, ignore_curr_inst}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midld_pc", pc, 32'h0);
    chk("midld_ign", {31'b0, ignore_curr_inst}, 32'd1);
    chk("jalr_link", mem[130], 32'h24);
    ldw(131, 32'hDEAD_BEEF);
    ldw(0, enc_s(32'h20C, 10, 0, 2));
    ldw(1, enc_j(0, 0));
    rst_n = 1'b1;
    tick(12);
    chk("midld_rd", mem[131], 32'h0);

    // Random programs against the reference model
    for (int r = 0; r < 8; r++) begin
      int np;
      do_reset();
      prog[0] = enc_i(32'h400, 0, 0, 31, 7'h13);
      for (int i = 1; i <= 40; i++) prog[i] = rand_inst(4 * i);
      for (int i = 1; i <= 30; i++) prog[40 + i] = enc_s(32'h200 + 4 * i, i, 31, 2);
      prog[71] = enc_j(0, 0);
      np = 72;
      for (int i = 0; i < np; i++) ldw(i, prog[i]);
      for (int w = 0; w < 64; w++) ldw(256 + w, $urandom);
      for (int w = 0; w < 31; w++) ldw(384 + w, 0);
      iss_run(32'(4 * (np - 1)));
      rst_n = 1'b1;
      tick(3 * np + 40);
      for (int w = 0; w < 64; w++) chk($sformatf("rnd%0d_data%0d", r, w), mem[256 + w], rmw[256 + w]);
      for (int w = 1; w < 31; w++) chk($sformatf("rnd%0d_x%0d", r, w), mem[384 + w], rmw[384 + w]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
